// File: rtl/mig7_tester_pkg.sv
// Shared constants, FSM state type and the data pattern for the MIG7 traffic tester.
package mig7_tester_pkg;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    // Widest app data bus supported; callers size the pattern down with DWIDTH'(...)
    localparam int MAX_DWIDTH = 1024;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RDWAIT,
        S_DONE
    } state_t;

    // Every 32-bit lane carries the same value, so truncating to DWIDTH yields DWIDTH/32 copies.
    function automatic logic [MAX_DWIDTH-1:0] word(input logic [31:0] a, input logic [31:0] s);
        return {(MAX_DWIDTH/32){a ^ s}};
    endfunction

endpackage

// File: rtl/mig7_tester_checker.sv
// In-order read-return checker: tracks the expected address, compares each returned word,
// counts mismatches (saturating) and captures the address of the first one.
module mig7_tester_checker
    import mig7_tester_pkg::*;
#(
    parameter int                AWIDTH     = 28,
    parameter int                DWIDTH     = 128,
    parameter int                BURSTS     = 1024,
    parameter int                ADDR_STEP  = 8,
    parameter logic [AWIDTH-1:0] START_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              restart,
    input  logic              enable,
    input  logic [31:0]       seed,
    input  logic [DWIDTH-1:0] rd_data,
    input  logic              rd_valid,
    output logic              rcv_done,
    output logic [31:0]       err_cnt,
    output logic              err_flag,
    output logic [AWIDTH-1:0] first_err_addr
);

    localparam int CW = $clog2(BURSTS + 1);

    logic [AWIDTH-1:0] chk_addr;
    logic [CW-1:0]     rcv_cnt;
    logic              take;
    logic              mismatch;

    assign rcv_done = (rcv_cnt == CW'(BURSTS));
    // Surplus returns past BURSTS are dropped without being compared
    assign take     = enable && rd_valid && !rcv_done;
    assign mismatch = take && (rd_data != DWIDTH'(word(32'(chk_addr), seed)));

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_addr       <= START_ADDR;
            rcv_cnt        <= '0;
            err_cnt        <= '0;
            err_flag       <= 1'b0;
            first_err_addr <= '0;
        end else begin
            if (restart) begin
                chk_addr <= START_ADDR;
                rcv_cnt  <= '0;
            end else if (take) begin
                chk_addr <= chk_addr + AWIDTH'(ADDR_STEP);
                rcv_cnt  <= rcv_cnt + CW'(1);
            end
            if (clear) begin
                err_cnt        <= '0;
                err_flag       <= 1'b0;
                first_err_addr <= '0;
            end else if (mismatch) begin
                if (err_cnt != '1)
                    err_cnt <= err_cnt + 32'd1;
                err_flag <= 1'b1;
                if (err_cnt == '0)
                    first_err_addr <= chk_addr;
            end
        end
    end

endmodule

// File: rtl/mig7_tester.sv
// MIG7 app-interface traffic generator: writes a pattern over an address window, reads it back
// and checks it. Optional error injection is enabled by defining MIG7_TESTER_ERR_INJECT_EN.
module mig7_tester
    import mig7_tester_pkg::*;
#(
    parameter int                AWIDTH     = 28,
    parameter int                DWIDTH     = 128,
    parameter int                MWIDTH     = DWIDTH / 8,
    parameter int                BURSTS     = 1024,
    parameter int                ADDR_STEP  = 8,
    parameter logic [AWIDTH-1:0] START_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              loop,
    input  logic              stop,
    input  logic              inject,
    output logic [AWIDTH-1:0] app_addr,
    output logic [2:0]        app_cmd,
    output logic              app_en,
    output logic [DWIDTH-1:0] app_wdf_data,
    output logic              app_wdf_end,
    output logic [MWIDTH-1:0] app_wdf_mask,
    output logic              app_wdf_wren,
    input  logic [DWIDTH-1:0] app_rd_data,
    input  logic              app_rd_data_end,
    input  logic              app_rd_data_valid,
    input  logic              app_rdy,
    input  logic              app_wdf_rdy,
    output logic              app_sr_req,
    output logic              app_ref_req,
    output logic              app_zq_req,
    input  logic              app_sr_active,
    input  logic              app_ref_ack,
    input  logic              app_zq_ack,
    input  logic              init_calib_complete,
    output logic              busy,
    output logic              done,
    output logic [31:0]       pass_cnt,
    output logic [31:0]       err_cnt,
    output logic              err_flag,
    output logic [AWIDTH-1:0] first_err_addr
);

    localparam int CW = $clog2(BURSTS + 1);

    state_t            state, state_nx;
    logic [AWIDTH-1:0] addr;
    logic [CW-1:0]     cnt;
    logic              cmd_done, dat_done;
    logic              cmd_ok, dat_ok;
    logic              loop_q, stop_q;
    logic              last_cmd;
    logic              rcv_done;
    logic              chk_clear, chk_restart;
    logic [DWIDTH-1:0] wr_word;
    logic              unused_ok;

    assign last_cmd = (cnt == CW'(BURSTS - 1));
    assign busy     = (state == S_WR) || (state == S_RD) || (state == S_RDWAIT);
    assign done     = (state == S_DONE);

    assign app_addr     = addr;
    assign app_wdf_data = app_wdf_wren ? wr_word : '0;
    assign app_wdf_end  = app_wdf_wren;
    assign app_wdf_mask = '0;
    assign app_sr_req   = 1'b0;
    assign app_ref_req  = 1'b0;
    assign app_zq_req   = 1'b0;

`ifdef MIG7_TESTER_ERR_INJECT_EN
    logic inj_armed;

    always_ff @(posedge clk) begin
        if (rst)
            inj_armed <= 1'b0;
        else if (inj_armed && app_wdf_wren && app_wdf_rdy)
            inj_armed <= 1'b0;
        else if (inject)
            inj_armed <= 1'b1;
    end

    assign wr_word   = DWIDTH'(word(32'(addr), pass_cnt)) ^ DWIDTH'(inj_armed);
    assign unused_ok = ^{app_rd_data_end, app_sr_active, app_ref_ack, app_zq_ack};
`else
    assign wr_word   = DWIDTH'(word(32'(addr), pass_cnt));
    assign unused_ok = ^{app_rd_data_end, app_sr_active, app_ref_ack, app_zq_ack, inject};
`endif

    always_comb begin
        state_nx     = state;
        app_en       = 1'b0;
        app_cmd      = CMD_WR;
        app_wdf_wren = 1'b0;
        cmd_ok       = 1'b0;
        dat_ok       = 1'b0;
        chk_clear    = 1'b0;
        chk_restart  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                // From DONE calibration is already known good
                if (start && (init_calib_complete || state == S_DONE)) begin
                    state_nx    = S_WR;
                    chk_clear   = 1'b1;
                    chk_restart = 1'b1;
                end
            end
            S_WR: begin
                app_en       = !cmd_done;
                app_wdf_wren = !dat_done;
                cmd_ok       = cmd_done || app_rdy;
                dat_ok       = dat_done || app_wdf_rdy;
                if (cmd_ok && dat_ok && last_cmd)
                    state_nx = S_RD;
            end
            S_RD: begin
                app_en  = 1'b1;
                app_cmd = CMD_RD;
                if (app_rdy && last_cmd)
                    state_nx = S_RDWAIT;
            end
            S_RDWAIT: begin
                if (rcv_done) begin
                    if (loop_q && !stop_q && !stop) begin
                        state_nx    = S_WR;
                        chk_restart = 1'b1;
                    end else begin
                        state_nx = S_DONE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            addr     <= '0;
            cnt      <= '0;
            cmd_done <= 1'b0;
            dat_done <= 1'b0;
            loop_q   <= 1'b0;
            stop_q   <= 1'b0;
            pass_cnt <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE, S_DONE: begin
                    if (state_nx == S_WR) begin
                        loop_q   <= loop;
                        stop_q   <= 1'b0;
                        pass_cnt <= '0;
                        addr     <= START_ADDR;
                        cnt      <= '0;
                        cmd_done <= 1'b0;
                        dat_done <= 1'b0;
                    end
                end
                S_WR: begin
                    // Command and data may be accepted on different cycles; hold whichever finished first
                    if (cmd_ok && dat_ok) begin
                        cmd_done <= 1'b0;
                        dat_done <= 1'b0;
                        addr     <= last_cmd ? START_ADDR : addr + AWIDTH'(ADDR_STEP);
                        cnt      <= last_cmd ? '0 : cnt + CW'(1);
                    end else begin
                        cmd_done <= cmd_ok;
                        dat_done <= dat_ok;
                    end
                end
                S_RD: begin
                    if (app_rdy) begin
                        addr <= last_cmd ? START_ADDR : addr + AWIDTH'(ADDR_STEP);
                        cnt  <= last_cmd ? '0 : cnt + CW'(1);
                    end
                end
                S_RDWAIT: begin
                    if (rcv_done) begin
                        pass_cnt <= pass_cnt + 32'd1;
                        addr     <= START_ADDR;
                    end
                end
                default: ;
            endcase
            if (stop && busy)
                stop_q <= 1'b1;
        end
    end

    mig7_tester_checker #(
        .AWIDTH    (AWIDTH),
        .DWIDTH    (DWIDTH),
        .BURSTS    (BURSTS),
        .ADDR_STEP (ADDR_STEP),
        .START_ADDR(START_ADDR)
    ) u_checker (
        .clk           (clk),
        .rst           (rst),
        .clear         (chk_clear),
        .restart       (chk_restart),
        .enable        ((state == S_RD) || (state == S_RDWAIT)),
        .seed          (pass_cnt),
        .rd_data       (app_rd_data),
        .rd_valid      (app_rd_data_valid),
        .rcv_done      (rcv_done),
        .err_cnt       (err_cnt),
        .err_flag      (err_flag),
        .first_err_addr(first_err_addr)
    );

endmodule

// File: tb/tb_mig7_tester.sv
// Directed bench for mig7_tester: two instances (16-burst window at 0, 8-burst window wrapping
// past 2^28) driven by a small MIG memory model with optional random back-pressure.
module tb_mig7_tester;
    import mig7_tester_pkg::*;

    localparam int AW = 28;
    localparam int DW = 128;
    localparam int MW = DW / 8;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic rst, calib, loop, stop, inject;
    logic start [2];
    logic [AW-1:0] app_addr [2];
    logic [2:0]    app_cmd [2];
    logic          app_en [2], app_wdf_end [2], app_wdf_wren [2];
    logic          app_sr_req [2], app_ref_req [2], app_zq_req [2];
    logic [DW-1:0] app_wdf_data [2], app_rd_data [2];
    logic [MW-1:0] app_wdf_mask [2];
    logic          app_rd_data_valid [2], app_rdy [2], app_wdf_rdy [2];
    logic          busy [2], done [2], err_flag [2];
    logic [31:0]   pass_cnt [2], err_cnt [2];
    logic [AW-1:0] first_err_addr [2];

    mig7_tester #(.AWIDTH(AW), .DWIDTH(DW), .BURSTS(16), .ADDR_STEP(8), .START_ADDR(28'h0)) u0 (
        .clk(clk_sys), .rst(rst), .start(start[0]), .loop(loop), .stop(stop), .inject(inject),
        .app_addr(app_addr[0]), .app_cmd(app_cmd[0]), .app_en(app_en[0]),
        .app_wdf_data(app_wdf_data[0]), .app_wdf_end(app_wdf_end[0]), .app_wdf_mask(app_wdf_mask[0]),
        .app_wdf_wren(app_wdf_wren[0]), .app_rd_data(app_rd_data[0]), .app_rd_data_end(1'b0),
        .app_rd_data_valid(app_rd_data_valid[0]), .app_rdy(app_rdy[0]), .app_wdf_rdy(app_wdf_rdy[0]),
        .app_sr_req(app_sr_req[0]), .app_ref_req(app_ref_req[0]), .app_zq_req(app_zq_req[0]),
        .app_sr_active(1'b0), .app_ref_ack(1'b0), .app_zq_ack(1'b0), .init_calib_complete(calib),
        .busy(busy[0]), .done(done[0]), .pass_cnt(pass_cnt[0]), .err_cnt(err_cnt[0]),
        .err_flag(err_flag[0]), .first_err_addr(first_err_addr[0])
    );

    mig7_tester #(.AWIDTH(AW), .DWIDTH(DW), .BURSTS(8), .ADDR_STEP(8), .START_ADDR(28'hFFFFFE0)) u1 (
        .clk(clk_sys), .rst(rst), .start(start[1]), .loop(loop), .stop(stop), .inject(inject),
        .app_addr(app_addr[1]), .app_cmd(app_cmd[1]), .app_en(app_en[1]),
        .app_wdf_data(app_wdf_data[1]), .app_wdf_end(app_wdf_end[1]), .app_wdf_mask(app_wdf_mask[1]),
        .app_wdf_wren(app_wdf_wren[1]), .app_rd_data(app_rd_data[1]), .app_rd_data_end(1'b0),
        .app_rd_data_valid(app_rd_data_valid[1]), .app_rdy(app_rdy[1]), .app_wdf_rdy(app_wdf_rdy[1]),
        .app_sr_req(app_sr_req[1]), .app_ref_req(app_ref_req[1]), .app_zq_req(app_zq_req[1]),
        .app_sr_active(1'b0), .app_ref_ack(1'b0), .app_zq_ack(1'b0), .init_calib_complete(calib),
        .busy(busy[1]), .done(done[1]), .pass_cnt(pass_cnt[1]), .err_cnt(err_cnt[1]),
        .err_flag(err_flag[1]), .first_err_addr(first_err_addr[1])
    );

    // Memory model state
    logic [AW-1:0] wq_a [2][$];
    logic [DW-1:0] wq_d [2][$];
    logic [AW-1:0] rq   [2][$];
    logic [AW-1:0] wl_a [2][$];
    logic [DW-1:0] wl_d [2][$];
    logic [DW-1:0] mem [logic [AW:0]];
    logic          rnd, corrupt_en;
    logic [AW-1:0] corrupt_addr;
    int            clr_gen = 0, clr_seen = 0, end_bad = 0;

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; handshakes recorded here are the ones the next rising edge sees
    always @(negedge clk_sys) begin : model
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        if (clr_gen != clr_seen) begin
            clr_seen = clr_gen;
            for (int k = 0; k < 2; k++) begin
                wq_a[k].delete(); wq_d[k].delete(); rq[k].delete();
                wl_a[k].delete(); wl_d[k].delete();
            end
        end
        for (int k = 0; k < 2; k++) begin
            app_rdy[k]           = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            app_wdf_rdy[k]       = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            app_rd_data_valid[k] = 1'b0;
            if (rq[k].size() != 0 && (!rnd || $urandom_range(0, 1) == 1)) begin
                a = rq[k].pop_front();
                app_rd_data[k] = mem[{k[0], a}];
                if (corrupt_en && k == 0 && a == corrupt_addr)
                    app_rd_data[k][5] = ~app_rd_data[k][5];
                app_rd_data_valid[k] = 1'b1;
            end
            if (app_wdf_end[k] !== app_wdf_wren[k])
                end_bad++;
            if (app_en[k] && app_rdy[k]) begin
                if (app_cmd[k] == CMD_WR) wq_a[k].push_back(app_addr[k]);
                else if (app_cmd[k] == CMD_RD) rq[k].push_back(app_addr[k]);
            end
            if (app_wdf_wren[k] && app_wdf_rdy[k])
                wq_d[k].push_back(app_wdf_data[k]);
            while (wq_a[k].size() != 0 && wq_d[k].size() != 0) begin
                a = wq_a[k].pop_front();
                d = wq_d[k].pop_front();
                mem[{k[0], a}] = d;
                wl_a[k].push_back(a);
                wl_d[k].push_back(d);
            end
        end
    end

    task automatic clear_model();
        clr_gen++;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic pulse_start(input int k);
        @(negedge clk_sys); start[k] = 1'b1;
        @(negedge clk_sys); start[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget);
        int n = 0;
        while (!done[k] && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        chk("done_in_time", done[k], 1);
    endtask

    initial begin
        int n;
        logic ok;
        rst = 1'b1; calib = 1'b0; loop = 1'b0; stop = 1'b0; inject = 1'b0;
        start[0] = 1'b0; start[1] = 1'b0;
        rnd = 1'b0; corrupt_en = 1'b0; corrupt_addr = '0;
        app_rd_data[0] = '0; app_rd_data[1] = '0;
        repeat (3) @(negedge clk_sys);
        rst = 1'b0;
        @(negedge clk_sys);

        for (int k = 0; k < 2; k++) begin
            chk("rst_busy", busy[k], 0);
            chk("rst_done", done[k], 0);
            chk("rst_app_en", {app_en[k], app_wdf_wren[k]}, 0);
            chk("rst_counters", {pass_cnt[k], err_cnt[k], err_flag[k], first_err_addr[k]}, 0);
            chk("tied_outputs", {app_sr_req[k], app_ref_req[k], app_zq_req[k], app_wdf_mask[k]}, 0);
        end

        // start without calibration is ignored
        pulse_start(0);
        repeat (5) @(negedge clk_sys);
        chk("nocal_busy", busy[0], 0);
        chk("nocal_app_en", app_en[0], 0);

        // single ideal pass
        calib = 1'b1;
        clear_model();
        pulse_start(0);
        wait_done(0, 400);
        chk("t1_pass_cnt", pass_cnt[0], 1);
        chk("t1_err_cnt", err_cnt[0], 0);
        chk("t1_busy", busy[0], 0);
        chk("t1_nwrites", wl_a[0].size(), 16);
        chk("t1_last_addr", wl_a[0][15], 28'h78);
        chk("t1_data5", wl_d[0][5], {4{32'h28}});
        chk("wdf_end_eq_wren", end_bad, 0);

        // random back-pressure on command and data independently
        rnd = 1'b1;
        clear_model();
        pulse_start(0);
        wait_done(0, 3000);
        rnd = 1'b0;
        ok = (wl_a[0].size() == 16);
        for (int i = 0; i < 16 && ok; i++)
            ok = (wl_a[0][i] == AW'(i * 8)) && (wl_d[0][i] == {4{32'(i * 8)}});
        chk("t2_nwrites", wl_a[0].size(), 16);
        chk("t2_writes_ok", ok, 1);
        chk("t2_err_cnt", err_cnt[0], 0);
        chk("t2_pass_cnt", pass_cnt[0], 1);

        // model corrupts the word at 0x28
        corrupt_en = 1'b1; corrupt_addr = 28'h28;
        clear_model();
        pulse_start(0);
        wait_done(0, 400);
        corrupt_en = 1'b0;
        chk("t3_err_cnt", err_cnt[0], 1);
        chk("t3_err_flag", err_flag[0], 1);
        chk("t3_first_err", first_err_addr[0], 28'h28);

        // loop, stop during pass 3
        loop = 1'b1;
        clear_model();
        pulse_start(0);
        n = 0;
        while (pass_cnt[0] != 2 && n < 400) begin
            @(negedge clk_sys);
            n++;
        end
        chk("t4_reach_pass2", pass_cnt[0], 2);
        stop = 1'b1;
        @(negedge clk_sys);
        stop = 1'b0; loop = 1'b0;
        wait_done(0, 400);
        chk("t4_pass_cnt", pass_cnt[0], 3);
        chk("t4_err_cnt", err_cnt[0], 0);
        chk("t4_nwrites", wl_a[0].size(), 48);
        chk("t4_seed1_w0", wl_d[0][16], {4{32'h1}});
        chk("t4_seed1_w1", wl_d[0][17], {4{32'h9}});
        chk("t4_seed2_w0", wl_d[0][32], {4{32'h2}});

        // window wrapping past the top of the address space
        clear_model();
        pulse_start(1);
        wait_done(1, 400);
        chk("t5_err_cnt", err_cnt[1], 0);
        chk("t5_pass_cnt", pass_cnt[1], 1);
        chk("t5_first_addr", wl_a[1][0], 28'hFFFFFE0);
        chk("t5_first_data", wl_d[1][0], {4{32'h0FFFFFE0}});
        chk("t5_wrap_addr", wl_a[1][4], 28'h0);
        chk("t5_last_addr", wl_a[1][7], 28'h18);

        // reset in the middle of the read phase
        clear_model();
        pulse_start(0);
        n = 0;
        while (!(app_en[0] && app_cmd[0] == CMD_RD) && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        chk("t6_reached_rd", {app_en[0], app_cmd[0]}, {1'b1, CMD_RD});
        repeat (3) @(negedge clk_sys);
        rst = 1'b1;
        @(negedge clk_sys);
        chk("t6_rst_app_en", app_en[0], 0);
        rst = 1'b0;
        repeat (20) @(negedge clk_sys);
        chk("t6_err_cnt", err_cnt[0], 0);
        chk("t6_state", {busy[0], done[0]}, 0);
        chk("t6_pass_cnt", pass_cnt[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
